dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0; 0 = round-robin between masters, 1 = master 1 (data) always wins a tie.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_address  input  32  instruction-fetch byte address.
REQ-005 m0_read  input  1  instruction-fetch read request, held until acknowledged.
REQ-006 m0_waitrequest  output  1  high while m0 request pending and not acknowledged.
REQ-007 m0_readdata  output  32  registered read data for m0.
REQ-008 m1_address  input  32  data-port byte address.
REQ-009 m1_read  input  1  data-port read request.
REQ-010 m1_write  input  1  data-port write request.
REQ-011 m1_writedata  input  32  data-port write data.
REQ-012 m1_waitrequest  output  1  high while m1 request pending and not acknowledged.
REQ-013 m1_readdata  output  32  registered read data for m1.
REQ-014 mem_address  output  32  byte address to the shared data RAM, passed unmodified (RAM does word indexing).
REQ-015 mem_read  output  1  read strobe to RAM.
REQ-016 mem_write  output  1  write strobe to RAM (RAM commits on rising edge).
REQ-017 mem_writedata  output  32  write data to RAM.
REQ-018 mem_readdata  input  32  combinational read data from RAM.

Function
REQ-019 State machine SHALL have states IDLE, SERVE0, SERVE1, ACK0, ACK1.
REQ-020 IDLE: requests sampled; m0 request = m0_read; m1 request = m1_read | m1_write; none -> stay IDLE.
REQ-021 IDLE, single requester k -> SERVEk next edge.
REQ-022 IDLE, both requesting: FIXED_PRIO=1 -> SERVE1; FIXED_PRIO=0 -> master not granted last (last_grant register).
REQ-023 SERVEk: mem_* driven from master k, mem_address = mk_address; mem_read/mem_write asserted exactly this one cycle; last_grant <= k; -> ACKk next edge.
REQ-024 SERVEk: mem_readdata captured into mk_readdata at the closing edge; writes commit to RAM at the same edge.
REQ-025 ACKk: mk_waitrequest = 0 for exactly this cycle; mk_readdata valid; -> IDLE next edge.
REQ-026 Latency: request seen in IDLE at cycle N -> ack (waitrequest low) in cycle N+2; one transaction per 3 cycles max.
REQ-027 mk_waitrequest = request_k & !(state == ACKk); both low when no request.
REQ-028 Outside SERVE0/SERVE1: mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0.
REQ-029 SERVE0: mem_write = 0, mem_writedata = 0.
REQ-030 m1_read and m1_write both high: write performed, mem_read also asserted; m1_readdata captures pre-write RAM contents.
REQ-031 Request deasserted during SERVEk: transaction still completes, ACKk cycle still entered; no retry.
REQ-032 Request still asserted in ACKk is treated as new request in the following IDLE (no back-to-back skip of IDLE).
REQ-033 mk_readdata holds its value until the next SERVEk of the same master; write-only transactions also update m1_readdata.
REQ-034 mem_write SHALL be gated by !reset so no write commits on a reset edge.

Reset
REQ-035 reset high at rising edge -> state IDLE, last_grant = 1 (m0 wins first tie), m0_readdata = m1_readdata = 0, regardless of current state.
REQ-036 During reset cycle all mem_* outputs = 0; waitrequest follows REQ-027 with state IDLE.
REQ-037 Transaction interrupted by reset is dropped; no ACK generated.

Verification
REQ-038 m0_read=1, m0_address=0x0, RAM word0=0x78563412 -> m0_waitrequest high 2 cycles, low in 3rd, m0_readdata=0x78563412.
REQ-039 m1_write=1, address 0x10, data 0xDEADBEEF; then m1_read at 0x10 -> mem_write one cycle pulse, readback 0xDEADBEEF.
REQ-040 Both request continuously, FIXED_PRIO=0, after reset -> grants alternate m0,m1,m0,m1; each acked every 6 cycles.
REQ-041 Both request, FIXED_PRIO=1 -> m1 acked every 3 cycles, m0 starved while m1 held.
REQ-042 reset asserted in SERVE1 with m1_write=1 to 0x20 -> RAM word 0x20 unchanged, state IDLE, no m1 ack, readdata 0.
REQ-043 m1 request dropped in SERVE1 -> ACK1 still occurs, then IDLE with m1_waitrequest low.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Bus bundle for the two-master DRAM arbiter: instruction port (m0),
// data port (m1) and the shared single-port RAM side (mem).
interface dram_arbiter_if;
  logic [31:0] m0_address;
  logic        m0_read;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;

  logic [31:0] m1_address;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  // Arbiter side
  modport slave (
    input  m0_address, m0_read,
    output m0_waitrequest, m0_readdata,
    input  m1_address, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata
  );

  // Environment side: masters and RAM
  modport master (
    output m0_address, m0_read,
    input  m0_waitrequest, m0_readdata,
    output m1_address, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-master arbiter in front of a single-port RAM: one access per 3 cycles,
// round-robin or fixed data-port priority, registered read data per master.
module dram_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  dram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE0 = 3'd1,
    SERVE1 = 3'd2,
    ACK0   = 3'd3,
    ACK1   = 3'd4
  } state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic [31:0] m0_readdata_reg;
  logic [31:0] m1_readdata_reg;
  logic [31:0] mem_address_reg;
  logic [31:0] mem_writedata_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;

  logic req0;
  logic req1;
  logic grant1;

  assign req0 = bus.m0_read;
  assign req1 = bus.m1_read | bus.m1_write;

  // On a tie m1 wins under fixed priority, or when m0 was served last
  assign grant1 = req1 & (~req0 | FIXED_PRIO | ~last_grant_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      last_grant_reg    <= 1'b1;
      m0_readdata_reg   <= '0;
      m1_readdata_reg   <= '0;
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
    end else begin
      // Strobes live for the single SERVE cycle only
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant1) begin
            state_reg         <= SERVE1;
            mem_address_reg   <= bus.m1_address;
            mem_read_reg      <= bus.m1_read;
            mem_write_reg     <= bus.m1_write;
            mem_writedata_reg <= bus.m1_writedata;
          end else if (req0) begin
            state_reg       <= SERVE0;
            mem_address_reg <= bus.m0_address;
            mem_read_reg    <= 1'b1;
          end
        end
        SERVE0: begin
          m0_readdata_reg <= bus.mem_readdata;
          last_grant_reg  <= 1'b0;
          state_reg       <= ACK0;
        end
        SERVE1: begin
          // RAM read is combinational, so this is the pre-write content
          m1_readdata_reg <= bus.mem_readdata;
          last_grant_reg  <= 1'b1;
          state_reg       <= ACK1;
        end
        ACK0:    state_reg <= IDLE;
        ACK1:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A reset cycle looks like IDLE on every output, so nothing commits on that edge
  assign bus.mem_address    = reset ? '0 : mem_address_reg;
  assign bus.mem_writedata  = reset ? '0 : mem_writedata_reg;
  assign bus.mem_read       = mem_read_reg & ~reset;
  assign bus.mem_write      = mem_write_reg & ~reset;

  assign bus.m0_waitrequest = req0 & ~((state_reg == ACK0) & ~reset);
  assign bus.m1_waitrequest = req1 & ~((state_reg == ACK1) & ~reset);
  assign bus.m0_readdata    = m0_readdata_reg;
  assign bus.m1_readdata    = m1_readdata_reg;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: a round-robin instance on a RAM model
// and a fixed-priority instance on an address-derived data pattern.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  dram_arbiter_if bus ();
  dram_arbiter_if busp ();

  dram_arbiter #(.FIXED_PRIO(1'b0)) dut  (.clk(clk), .reset(reset), .bus(bus));
  dram_arbiter #(.FIXED_PRIO(1'b1)) dutp (.clk(clk), .reset(reset), .bus(busp));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  // 0: dut m0, 1: dut m1, 2: dutp m0, 3: dutp m1
  exp_t exp_q[4][$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int starve_lows = 0;
  logic starve_watch = 1'b0;
  logic [31:0] ram [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_init) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= (i == 0) ? 32'h78563412 : 32'h10000000 + i;
    end else if (bus.mem_write) begin
      ram[bus.mem_address[9:2]] <= bus.mem_writedata;
    end
  end

  assign bus.mem_readdata  = ram[bus.mem_address[9:2]];
  assign busp.mem_readdata = busp.mem_address ^ 32'hA5A50000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic pop_check(input int idx, input logic [31:0] data);
    exp_t e;
    if (exp_q[idx].size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_ack[%0d]: data 0x%08h at cycle %0d, none expected", idx, data, cyc);
    end else begin
      e = exp_q[idx].pop_front();
      $display("ack port %0d cycle %0d data 0x%08h (expected cycle %0d data 0x%08h)",
               idx, cyc, data, e.cyc, e.data);
      chk($sformatf("ack_cycle[%0d]", idx), cyc, e.cyc);
      chk($sformatf("ack_data[%0d]", idx), data, e.data);
    end
  endtask

  // Monitor: an ack is a pending request with waitrequest low
  always @(negedge clk) begin
    if (bus.m0_read && !bus.m0_waitrequest) pop_check(0, bus.m0_readdata);
    if ((bus.m1_read || bus.m1_write) && !bus.m1_waitrequest) pop_check(1, bus.m1_readdata);
    if (busp.m0_read && !busp.m0_waitrequest) pop_check(2, busp.m0_readdata);
    if ((busp.m1_read || busp.m1_write) && !busp.m1_waitrequest) pop_check(3, busp.m1_readdata);
    if (bus.mem_write) wr_pulses++;
    if (starve_watch && !busp.m0_waitrequest) starve_lows++;
  end

  // Issue one transaction from an IDLE cycle, check the SERVE-cycle RAM strobes,
  // wait (bounded) for the ack and release the request in the following IDLE cycle.
  task automatic txn(input int m, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rexp, input string tag);
    int c;
    logic got;
    c = cyc;
    if (m == 0) begin
      bus.m0_address = addr;
      bus.m0_read    = 1'b1;
    end else begin
      bus.m1_address   = addr;
      bus.m1_read      = rd;
      bus.m1_write     = wr;
      bus.m1_writedata = wdata;
    end
    exp_q[m].push_back('{rexp, c + 2});
    @(negedge clk);
    chk({tag, "_idle_mem_read"}, bus.mem_read, 1'b0);
    @(negedge clk);
    chk({tag, "_serve_addr"},  bus.mem_address, addr);
    chk({tag, "_serve_read"},  bus.mem_read, (m == 0) ? 1'b1 : rd);
    chk({tag, "_serve_write"}, bus.mem_write, (m == 0) ? 1'b0 : wr);
    chk({tag, "_serve_wdata"}, bus.mem_writedata, (m == 0 || !wr) ? 32'h0 : wdata);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = (m == 0) ? !bus.m0_waitrequest : !bus.m1_waitrequest;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no ack within 6 cycles, required ack", tag);
    end
    @(posedge clk); #1;
    if (m == 0) bus.m0_read = 1'b0;
    else begin
      bus.m1_read  = 1'b0;
      bus.m1_write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int wp;
    bus.m0_address = '0; bus.m0_read = 1'b0;
    bus.m1_address = '0; bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_writedata = '0;
    busp.m0_address = '0; busp.m0_read = 1'b0;
    busp.m1_address = '0; busp.m1_read = 1'b0; busp.m1_write = 1'b0; busp.m1_writedata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read",  bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr",  bus.mem_address, 32'h0);
    chk("rst_m0_rdata",  bus.m0_readdata, 32'h0);
    chk("rst_m1_rdata",  bus.m1_readdata, 32'h0);
    chk("rst_m0_wait",   bus.m0_waitrequest, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ram_init = 1'b0;

    // Instruction fetch of word 0
    txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h78563412, "r038");

    // Write then read back; write-only ack returns pre-write contents
    wp = wr_pulses;
    txn(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10000004, "w039");
    chk("w039_pulses", wr_pulses - wp, 1);
    chk("w039_ram", ram[4], 32'hDEADBEEF);
    txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "r039");

    // Read and write together
    txn(1, 1'b1, 1'b1, 32'h14, 32'h12345678, 32'h10000005, "rw030");
    chk("rw030_ram", ram[5], 32'h12345678);
    txn(1, 1'b1, 1'b0, 32'h14, 32'h0, 32'h12345678, "rd030");
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h10000002, "r0_word2");

    // m1 drops its request during SERVE1
    bus.m1_address = 32'hC;
    bus.m1_read = 1'b1;
    @(posedge clk); #1;
    bus.m1_read = 1'b0;
    @(negedge clk);
    chk("d043_serve_read", bus.mem_read, 1'b1);
    chk("d043_serve_addr", bus.mem_address, 32'hC);
    @(negedge clk);
    chk("d043_ack_wait", bus.m1_waitrequest, 1'b0);
    chk("d043_ack_rdata", bus.m1_readdata, 32'h10000003);
    @(posedge clk); #1;
    txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h10000001, "d043_next");

    // Round robin from reset: m0 first, then alternate
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    c = cyc;
    bus.m0_address = 32'h0;  bus.m0_read = 1'b1;
    bus.m1_address = 32'h18; bus.m1_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q[0].push_back('{32'h78563412, c + 2 + 6 * k});
      exp_q[1].push_back('{32'h10000006, c + 5 + 6 * k});
    end
    while (cyc < c + 18) begin
      @(posedge clk); #1;
    end
    bus.m0_read = 1'b0;
    bus.m1_read = 1'b0;
    chk("rr040_q0_left", exp_q[0].size(), 0);
    chk("rr040_q1_left", exp_q[1].size(), 0);

    // Reset during SERVE1 of a write
    wp = wr_pulses;
    bus.m1_address = 32'h20; bus.m1_writedata = 32'hCAFEF00D; bus.m1_write = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("r042_mem_write", bus.mem_write, 1'b0);
    chk("r042_mem_read",  bus.mem_read, 1'b0);
    chk("r042_mem_addr",  bus.mem_address, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r042_no_ack", bus.m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.m1_write = 1'b0;
    chk("r042_ram", ram[8], 32'h10000008);
    chk("r042_pulses", wr_pulses - wp, 0);
    chk("r042_m1_rdata", bus.m1_readdata, 32'h0);

    // Fixed priority: m1 every 3 cycles, m0 starved
    c = cyc;
    busp.m0_address = 32'h100; busp.m0_read = 1'b1;
    busp.m1_address = 32'h200; busp.m1_read = 1'b1;
    for (int k = 0; k < 4; k++) exp_q[3].push_back('{32'hA5A50200, c + 2 + 3 * k});
    starve_watch = 1'b1;
    while (cyc < c + 12) begin
      @(posedge clk); #1;
    end
    starve_watch = 1'b0;
    busp.m0_read = 1'b0;
    busp.m1_read = 1'b0;
    chk("fp041_m0_starved", starve_lows, 0);

    repeat (3) @(posedge clk);
    for (int q = 0; q < 4; q++) chk($sformatf("final_q%0d_left", q), exp_q[q].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
